// File: rtl/pc_unit_ras_if.sv
// Fetch-control bundle between the PC unit and its requesters: redirect requests,
// the current fetch address and return-address-stack status.
interface pc_unit_ras_if #(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CountWidth = $clog2(RAS_DEPTH) + 1;

  logic                  stall;
  logic                  pc_write;
  logic [PC_WIDTH-1:0]   pc_in;
  logic                  branch_taken;
  logic [PC_WIDTH-1:0]   branch_target;
  logic                  jump;
  logic                  call;
  logic                  ret;
  logic [PC_WIDTH-1:0]   jump_target;
  logic [PC_WIDTH-1:0]   pc_out;
  logic [CountWidth-1:0] ras_count;
  logic                  ras_full;
  logic                  ras_empty;
  logic                  ras_overflow;
  logic                  ras_underflow;
  logic                  misalign;

  modport master (
    output stall, pc_write, pc_in, branch_taken, branch_target, jump, call, ret, jump_target,
    input  pc_out, ras_count, ras_full, ras_empty, ras_overflow, ras_underflow, misalign
  );

  modport slave (
    input  stall, pc_write, pc_in, branch_taken, branch_target, jump, call, ret, jump_target,
    output pc_out, ras_count, ras_full, ras_empty, ras_overflow, ras_underflow, misalign
  );
endinterface

// File: rtl/pc_unit_ras.sv
// Program-counter unit with a circular return-address stack for call/return.
// Define PC_ALIGN_CHECK_EN to force redirect targets onto PC_STEP alignment and flag misalign.
module pc_unit_ras #(
  parameter int unsigned         PC_WIDTH     = 16,
  parameter int unsigned         PC_STEP      = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input logic           clk,
  input logic           rst_n,
  pc_unit_ras_if.slave  bus
);

  localparam int unsigned         PtrWidth   = $clog2(RAS_DEPTH);
  localparam int unsigned         CountWidth = PtrWidth + 1;
  localparam logic [PC_WIDTH-1:0] StepVal    = PC_WIDTH'(PC_STEP);
  localparam logic [PtrWidth-1:0] PtrLast    = PtrWidth'(RAS_DEPTH - 1);

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [PtrWidth-1:0]   ptr_q, ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [PC_WIDTH-1:0]   ras_q [RAS_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PtrWidth-1:0] ptr_inc, ptr_dec;
  logic [PC_WIDTH-1:0] ras_top;
  logic                full, empty;
  logic                push_en;
  logic                load_target;
  logic [PC_WIDTH-1:0] sel_target;
  logic [PC_WIDTH-1:0] aligned_target;

  assign pc_inc  = pc_q + StepVal;
  // ptr_q points at the next free slot; it wraps at RAS_DEPTH even when that is not a power of 2.
  assign ptr_inc = (ptr_q == PtrLast) ? '0 : ptr_q + PtrWidth'(1);
  assign ptr_dec = (ptr_q == '0) ? PtrLast : ptr_q - PtrWidth'(1);
  assign ras_top = ras_q[ptr_dec];
  assign full    = (count_q == CountWidth'(RAS_DEPTH));
  assign empty   = (count_q == '0);

  // Redirect target ranked below ret; call and jump share jump_target.
  always_comb begin
    sel_target  = '0;
    load_target = 1'b0;
    if (bus.call || bus.jump) begin
      sel_target  = bus.jump_target;
      load_target = 1'b1;
    end else if (bus.branch_taken) begin
      sel_target  = bus.branch_target;
      load_target = 1'b1;
    end else if (bus.pc_write) begin
      sel_target  = bus.pc_in;
      load_target = 1'b1;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [PC_WIDTH-1:0] AlignMask = PC_WIDTH'(PC_STEP - 1);

  logic misalign_q, misalign_d;

  assign aligned_target = sel_target & ~AlignMask;
  assign misalign_d     = !bus.stall && !bus.ret && load_target && |(sel_target & AlignMask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign bus.misalign = misalign_q;
`else
  assign aligned_target = sel_target;
  assign bus.misalign   = 1'b0;
`endif

  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    push_en     = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (!bus.stall) begin
      if (bus.ret) begin
        if (empty) begin
          pc_d        = pc_inc;
          underflow_d = 1'b1;
        end else begin
          pc_d    = ras_top;
          ptr_d   = ptr_dec;
          count_d = count_q - CountWidth'(1);
        end
      end else if (bus.call) begin
        pc_d    = aligned_target;
        push_en = 1'b1;
        ptr_d   = ptr_inc;
        // When full, ptr_q already sits on the oldest entry, so the push overwrites it.
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CountWidth'(1);
        end
      end else if (load_target) begin
        pc_d = aligned_target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_VECTOR;
      count_q     <= '0;
      ptr_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack contents need no reset; count_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_q[ptr_q] <= pc_inc;
    end
  end

  assign bus.pc_out        = pc_q;
  assign bus.ras_count     = count_q;
  assign bus.ras_full      = full;
  assign bus.ras_empty     = empty;
  assign bus.ras_overflow  = overflow_q;
  assign bus.ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed vector table, mid-cycle reset, then random traffic
// checked against a queue-based model of the PC/return-stack rules.
module tb_pc_unit_ras;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit AlignOn = 1'b1;
`else
  localparam bit AlignOn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  pc_unit_ras_if #(.PC_WIDTH(16), .RAS_DEPTH(4)) bus ();

  pc_unit_ras #(
    .PC_WIDTH    (16),
    .PC_STEP     (2),
    .RESET_VECTOR(16'h0000),
    .RAS_DEPTH   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, pw, br, jp, cl, rt;
    logic [15:0] pin, bt, jt;
    logic [15:0] exp_pc;
    int          exp_cnt;
    logic        exp_ovf, exp_unf, exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic pw, logic [15:0] pin, logic br, logic [15:0] bt,
                              logic jp, logic cl, logic rt, logic [15:0] jt, logic [15:0] pc,
                              int cnt, logic ovf, logic unf, logic mis);
    vec_t v;
    v.st = st; v.pw = pw; v.pin = pin; v.br = br; v.bt = bt;
    v.jp = jp; v.cl = cl; v.rt = rt; v.jt = jt;
    v.exp_pc = pc; v.exp_cnt = cnt; v.exp_ovf = ovf; v.exp_unf = unf; v.exp_mis = mis;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_all(string tag, logic [15:0] pc, int cnt, logic ovf, logic unf,
                           logic mis);
    check({tag, " pc"}, 32'(bus.pc_out), 32'(pc));
    check({tag, " count"}, 32'(bus.ras_count), 32'(cnt));
    check({tag, " full"}, 32'(bus.ras_full), 32'(cnt == 4));
    check({tag, " empty"}, 32'(bus.ras_empty), 32'(cnt == 0));
    check({tag, " overflow"}, 32'(bus.ras_overflow), 32'(ovf));
    check({tag, " underflow"}, 32'(bus.ras_underflow), 32'(unf));
    check({tag, " misalign"}, 32'(bus.misalign), 32'(mis));
  endtask

  task automatic drive(logic st, logic pw, logic [15:0] pin, logic br, logic [15:0] bt,
                       logic jp, logic cl, logic rt, logic [15:0] jt);
    bus.stall = st; bus.pc_write = pw; bus.pc_in = pin; bus.branch_taken = br;
    bus.branch_target = bt; bus.jump = jp; bus.call = cl; bus.ret = rt; bus.jump_target = jt;
  endtask

  // Reference model: architectural PC plus a return stack kept as a plain queue.
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  logic        m_ovf, m_unf, m_mis;

  task automatic model_step();
    logic [15:0] t;
    m_ovf = 1'b0; m_unf = 1'b0; m_mis = 1'b0;
    if (bus.stall) return;
    if (bus.ret) begin
      if (m_ras.size() != 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc  = m_pc + 16'd2;
        m_unf = 1'b1;
      end
      return;
    end
    if (bus.call || bus.jump) t = bus.jump_target;
    else if (bus.branch_taken) t = bus.branch_target;
    else if (bus.pc_write) t = bus.pc_in;
    else begin
      m_pc = m_pc + 16'd2;
      return;
    end
    if (AlignOn && t[0]) begin
      m_mis = 1'b1;
      t[0]  = 1'b0;
    end
    if (bus.call) begin
      m_ras.push_back(m_pc + 16'd2);
      if (m_ras.size() > 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
    end
    m_pc = t;
  endtask

  initial begin
    logic [15:0] a_pc;
    n_checks = 0;
    n_pass   = 0;
    drive(0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load something, then assert reset between edges: must clear without a clock.
    drive(0, 1, 16'h1234, 0, 16'h0, 0, 0, 0, 16'h0);
    @(posedge clk);
    #1;
    check_all("preload", 16'h1234, 0, 0, 0, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async reset", 16'h0000, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //             st pw pin       br bt        jp cl rt jt        pc       cnt ov un mi
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0002, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0004, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0006, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h1234, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h1234, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h1236, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h5678, 16'h5678, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hAAAA, 1, 0, 0, 16'h5678, 16'h5678, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h4444, 1, 16'hAAAA, 0, 0, 0, 16'h0000, 16'hAAAA, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0100, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0800, 16'h0800, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0802, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0102, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0010, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0020, 16'h0020, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0030, 16'h0030, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0040, 16'h0040, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0050, 16'h0050, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0060, 16'h0060, 4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0062, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0052, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0042, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0032, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0022, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0024, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0026, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'hFFFE, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'hFFFE, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h1111, 16'hFFFE, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'hFFFE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0300, 16'h0300, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0500, 16'h0002, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0004, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 16'hFFFE, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'hFFFE, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0400, 16'h0400, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0));
    a_pc = AlignOn ? 16'h1234 : 16'h1235;
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h1235, a_pc, 0, 0, 0, AlignOn));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, a_pc + 16'd2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'h3333, 0, 16'h0000, 0, 0, 1, 16'h0000, a_pc + 16'd4, 0, 0, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].pw, vecs[i].pin, vecs[i].br, vecs[i].bt,
            vecs[i].jp, vecs[i].cl, vecs[i].rt, vecs[i].jt);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt,
                vecs[i].exp_ovf, vecs[i].exp_unf, vecs[i].exp_mis);
    end

    // Random traffic against the model, starting from a fresh reset.
    drive(0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 16'h0000;
    m_ras.delete();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(7) == 0), ($urandom_range(3) == 0), 16'($urandom),
            ($urandom_range(3) == 0), 16'($urandom), ($urandom_range(4) == 0),
            ($urandom_range(3) == 0), ($urandom_range(3) == 0), 16'($urandom));
      @(posedge clk);
      #1;
      model_step();
      check_all($sformatf("rand%0d", n), m_pc, m_ras.size(), m_ovf, m_unf, m_mis);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
